// File: rtl/serial_full_add.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Optional build macro SERIAL_ADD_SUB_EN adds in_sub for a bit-serial full-subtract.
module serial_full_add #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             in_sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             s_bit;
   logic             c_nxt;
   logic             load;
   logic             last;
`ifdef SERIAL_ADD_SUB_EN
   logic             sub;
`endif

   function automatic logic bit_sum(input logic a, input logic b, input logic c);
      return a ^ b ^ c;
   endfunction

   function automatic logic maj(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic borrow(input logic a, input logic b, input logic bin);
      return (~a & b) | (~(a ^ b) & bin);
   endfunction

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign load      = in_valid && in_ready;
   assign last      = (state == RUN) && (cnt == LAST);

   always_comb begin
      s_bit = bit_sum(a_sh[0], b_sh[0], carry);
`ifdef SERIAL_ADD_SUB_EN
      c_nxt = sub ? borrow(a_sh[0], b_sh[0], carry) : maj(a_sh[0], b_sh[0], carry);
`else
      c_nxt = maj(a_sh[0], b_sh[0], carry);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load) state_nxt = RUN;
         RUN:     if (last) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         carry    <= 1'b0;
         out_sum  <= '0;
         out_cout <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
         sub      <= 1'b0;
`endif
      end else if (load) begin
         cnt   <= '0;
         carry <= in_cin;
`ifdef SERIAL_ADD_SUB_EN
         sub   <= in_sub;
`endif
      end else if (state == RUN) begin
         carry <= c_nxt;
         cnt   <= last ? '0 : cnt + 1'b1;
         if (last) begin
            out_sum  <= {s_bit, a_sh[WIDTH-1:1]};
            out_cout <= c_nxt;
         end
      end
   end

   // a_sh doubles as the sum register: each result bit enters at the MSB as an operand bit leaves the LSB
   always_ff @(posedge clk) begin
      if (load) begin
         a_sh <= in_a;
         b_sh <= in_b;
      end else if (state == RUN) begin
         a_sh <= {s_bit, a_sh[WIDTH-1:1]};
         b_sh <= b_sh >> 1;
      end
   end

endmodule

// File: tb/tb_serial_full_add.sv
// Randomized self-checking bench for serial_full_add against an arithmetic reference model.
// Define SERIAL_ADD_SUB_EN here as for the RTL to exercise the subtract mode.
module tb_serial_full_add;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
   logic         in_sub = 1'b0;
`endif
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_sum;
   logic         out_cout;

   int checks = 0;
   int errors = 0;

   serial_full_add #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
`ifdef SERIAL_ADD_SUB_EN
      .in_sub    (in_sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference: plain integer arithmetic on the whole operands
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic sub, output logic [W-1:0] s, output logic co);
      int unsigned ai, bi, ci, r;
      ai = a; bi = b; ci = c;
      if (sub) begin
         r  = (ai + (1 << W) - bi - ci) % (1 << W);
         co = (ai < bi + ci);
      end else begin
         r  = ai + bi + ci;
         co = (r >> W) & 1;
      end
      s = r[W-1:0];
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic sub, input int hold, input string tag);
      logic [W-1:0] es;
      logic         ec;
      int           lat;
      model(a, b, c, sub, es, ec);
      check({tag, " in_ready idle"}, in_ready, 1);
      in_a = a; in_b = b; in_cin = c;
`ifdef SERIAL_ADD_SUB_EN
      in_sub = sub;
`endif
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      in_sub = 1'($urandom);
`endif
      lat = 0;
      while (!out_valid && lat < W + 4) begin
         check({tag, " in_ready busy"}, in_ready, 0);
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, lat, W);
      check({tag, " sum"}, out_sum, es);
      check({tag, " cout"}, out_cout, ec);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom);
         @(posedge clk); #1;
         check({tag, " hold valid"}, out_valid, 1);
         check({tag, " hold sum"}, out_sum, es);
         check({tag, " hold cout"}, out_cout, ec);
         check({tag, " hold in_ready"}, in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " post valid"}, out_valid, 0);
      check({tag, " post in_ready"}, in_ready, 1);
      check({tag, " post sum kept"}, out_sum, es);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         rc, rs;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst out_valid", out_valid, 0);
      check("rst out_sum", out_sum, 0);
      check("rst out_cout", out_cout, 0);
      check("rst in_ready", in_ready, 1);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst release in_ready", in_ready, 1);

      run_op(8'h35, 8'h4A, 1'b0, 1'b0, 0, "add_35_4a");
      run_op(8'hFF, 8'h01, 1'b1, 1'b0, 1, "add_ff_01_c");
      run_op(8'h00, 8'h00, 1'b0, 1'b0, 0, "add_zero");
      run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 5, "backpressure");
      run_op(8'h12, 8'h34, 1'b0, 1'b0, 0, "after_bp");

      // abort an operation partway through RUN
      in_a = 8'h77; in_b = 8'h66; in_cin = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst out_valid", out_valid, 0);
      check("midrst in_ready", in_ready, 1);
      check("midrst out_sum", out_sum, 0);
      check("midrst out_cout", out_cout, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < W + 4; i++) begin
         @(posedge clk); #1;
         check("midrst no result", out_valid, 0);
      end
      run_op(8'h10, 8'h20, 1'b0, 1'b0, 0, "after_rst");

`ifdef SERIAL_ADD_SUB_EN
      run_op(8'h00, 8'h01, 1'b0, 1'b1, 0, "sub_00_01");
      run_op(8'h05, 8'h03, 1'b1, 1'b1, 2, "sub_05_03_b");
`endif

      for (int n = 0; n < 40; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         run_op(ra, rb, rc, rs, int'($urandom_range(0, 3)), "random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
